// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the instruction execution sequencer.
//   - function-select (FS) codes understood by func_unit
//       FS[3] = take Cin from the SR carry flag
//       FS[2] = forced carry-in of 1 (two's-complement subtract)
//   - format I / format II opcode values
//   - memory address bus (MAB) source selects
//   - sequencer state encoding
package exec_sequencer_pkg;

    localparam int FS_W_DEF = 6;

    localparam logic [5:0] FS_MOV  = 6'h00;
    localparam logic [5:0] FS_ADD  = 6'h01;
    localparam logic [5:0] FS_SUB  = 6'h06;
    localparam logic [5:0] FS_ADDC = 6'h09;
    localparam logic [5:0] FS_SUBC = 6'h0A;
    localparam logic [5:0] FS_BIC  = 6'h10;
    localparam logic [5:0] FS_BIS  = 6'h11;
    localparam logic [5:0] FS_XOR  = 6'h12;
    localparam logic [5:0] FS_AND  = 6'h13;
    localparam logic [5:0] FS_SWPB = 6'h21;
    localparam logic [5:0] FS_RRA  = 6'h22;
    localparam logic [5:0] FS_SXT  = 6'h23;
    localparam logic [5:0] FS_RRC  = 6'h28;

    // Format I (two-operand)
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_ADDC = 4'h6;
    localparam logic [3:0] OP_SUBC = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_CMP  = 4'h9;
    localparam logic [3:0] OP_DADD = 4'hA;
    localparam logic [3:0] OP_BIT  = 4'hB;
    localparam logic [3:0] OP_BIC  = 4'hC;
    localparam logic [3:0] OP_BIS  = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_AND  = 4'hF;

    // Format II (single-operand)
    localparam logic [3:0] OP2_RRC  = 4'h0;
    localparam logic [3:0] OP2_SWPB = 4'h1;
    localparam logic [3:0] OP2_RRA  = 4'h2;
    localparam logic [3:0] OP2_SXT  = 4'h3;

    localparam logic [1:0] MAB_PC  = 2'd0;
    localparam logic [1:0] MAB_SRC = 2'd1;
    localparam logic [1:0] MAB_DST = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SRC_EXT = 3'd1,
        ST_SRC_RD  = 3'd2,
        ST_DST_EXT = 3'd3,
        ST_DST_RD  = 3'd4,
        ST_EXEC    = 3'd5,
        ST_WB_MEM  = 3'd6,
        ST_RETIRE  = 3'd7
    } state_t;

endpackage

// File: rtl/exec_sequencer_fs_decode.sv
// fs_decode: combinational decode of {fmt2, opcode} into func_unit controls.
// Ports:
//   fmt2, opcode  in   instruction format and opcode
//   fs            out  function select (FS[3] mirrors cin_ext)
//   cin_ext       out  use SR carry as Cin (ADDC, SUBC, RRC)
//   writes_dst    out  result is written back (not CMP/BIT)
//   writes_sr     out  flags are updated (not MOV/SWPB)
//   reads_dst     out  destination operand must be fetched (format I except MOV)
//   legal         out  opcode is supported
module fs_decode
    import exec_sequencer_pkg::*;
#(
    parameter int FS_W = FS_W_DEF
) (
    input  logic            fmt2,
    input  logic [3:0]      opcode,
    output logic [FS_W-1:0] fs,
    output logic            cin_ext,
    output logic            writes_dst,
    output logic            writes_sr,
    output logic            reads_dst,
    output logic            legal
);

    logic [5:0] code;

    always_comb begin
        code       = FS_MOV;
        legal      = 1'b1;
        writes_dst = 1'b1;
        writes_sr  = 1'b1;
        reads_dst  = !fmt2;
        if (fmt2) begin
            case (opcode)
                OP2_RRC:  code = FS_RRC;
                OP2_SWPB: begin code = FS_SWPB; writes_sr = 1'b0; end
                OP2_RRA:  code = FS_RRA;
                OP2_SXT:  code = FS_SXT;
                default:  legal = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_MOV:  begin code = FS_MOV; writes_sr = 1'b0; reads_dst = 1'b0; end
                OP_ADD:  code = FS_ADD;
                OP_ADDC: code = FS_ADDC;
                OP_SUBC: code = FS_SUBC;
                OP_SUB:  code = FS_SUB;
                OP_CMP:  begin code = FS_SUB; writes_dst = 1'b0; end
                OP_BIT:  begin code = FS_AND; writes_dst = 1'b0; end
                OP_BIC:  code = FS_BIC;
                OP_BIS:  code = FS_BIS;
                OP_XOR:  code = FS_XOR;
                OP_AND:  code = FS_AND;
                default: legal = 1'b0;   // 0..3 and DADD
            endcase
        end
        if (!legal) begin
            code       = FS_MOV;
            writes_dst = 1'b0;
            writes_sr  = 1'b0;
            reads_dst  = 1'b0;
        end
        fs      = FS_W'(code);
        cin_ext = code[3];
    end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle controller sequencing func_unit for one decoded
// instruction: optional extension-word / operand fetches, one execute cycle,
// optional memory writeback, then a one-cycle retire.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (accept = valid & ready)
//   fmt2, opcode, bw, as, ad decoded fields, sampled only at accept
//   mem_req/mem_we/mem_ack   memory bus handshake, mab_sel picks the address
//   ext_ld, src_ld, dst_ld   operand latch enables (pulse with mem_ack)
//   fs, bw_out, cin_ext      func_unit controls
//   rf_we, rf_inc, inc_two   register-file writeback / post-increment
//   pc_inc, sr_we            PC advance after extension word, SR flag load
//   done, illegal            one-cycle retire / reject pulses
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int FS_W = FS_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            fmt2,
    input  logic [3:0]      opcode,
    input  logic            bw,
    input  logic [1:0]      as,
    input  logic            ad,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    output logic [1:0]      mab_sel,
    output logic            ext_ld,
    output logic            src_ld,
    output logic            dst_ld,
    output logic [FS_W-1:0] fs,
    output logic            bw_out,
    output logic            cin_ext,
    output logic            rf_we,
    output logic            rf_inc,
    output logic            inc_two,
    output logic            pc_inc,
    output logic            sr_we,
    output logic            done,
    output logic            illegal
);

    state_t          state, nxt;
    logic            fmt2_r, bw_r, ad_r, illegal_r;
    logic [3:0]      opcode_r;
    logic [1:0]      as_r;
    logic            accept;
    logic            dec_fmt2;
    logic [3:0]      dec_opcode;
    logic [FS_W-1:0] dec_fs;
    logic            dec_cin, dec_writes_dst, dec_writes_sr, dec_reads_dst, dec_legal;

    assign accept = instr_valid && (state == ST_IDLE);

    // In IDLE the decoder looks at the live fields so legality is known at
    // accept; once busy it looks at the latched copy.
    assign dec_fmt2   = (state == ST_IDLE) ? fmt2   : fmt2_r;
    assign dec_opcode = (state == ST_IDLE) ? opcode : opcode_r;

    fs_decode #(.FS_W(FS_W)) u_fs_decode (
        .fmt2       (dec_fmt2),
        .opcode     (dec_opcode),
        .fs         (dec_fs),
        .cin_ext    (dec_cin),
        .writes_dst (dec_writes_dst),
        .writes_sr  (dec_writes_sr),
        .reads_dst  (dec_reads_dst),
        .legal      (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            fmt2_r    <= 1'b0;
            opcode_r  <= 4'd0;
            bw_r      <= 1'b0;
            as_r      <= 2'd0;
            ad_r      <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state     <= nxt;
            illegal_r <= accept && !dec_legal;
            if (accept) begin
                fmt2_r   <= fmt2;
                opcode_r <= opcode;
                bw_r     <= bw;
                as_r     <= as;
                ad_r     <= ad;
            end
        end
    end

    assign bw_out  = bw_r;
    assign illegal = illegal_r;

    always_comb begin
        nxt         = state;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mab_sel     = MAB_PC;
        ext_ld      = 1'b0;
        src_ld      = 1'b0;
        dst_ld      = 1'b0;
        fs          = '0;
        cin_ext     = 1'b0;
        rf_we       = 1'b0;
        rf_inc      = 1'b0;
        inc_two     = 1'b0;
        pc_inc      = 1'b0;
        sr_we       = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (accept && dec_legal) begin
                    if (as == 2'b01)       nxt = ST_SRC_EXT;
                    else if (as[1])        nxt = ST_SRC_RD;
                    else if (ad && !fmt2)  nxt = ST_DST_EXT;
                    else                   nxt = ST_EXEC;
                end
            end
            ST_SRC_EXT: begin
                mem_req = 1'b1;
                mab_sel = MAB_PC;
                if (mem_ack) begin
                    ext_ld = 1'b1;
                    pc_inc = 1'b1;
                    nxt    = ST_SRC_RD;
                end
            end
            ST_SRC_RD: begin
                mem_req = 1'b1;
                mab_sel = MAB_SRC;
                if (mem_ack) begin
                    src_ld = 1'b1;
                    if (as_r == 2'b11) begin
                        rf_inc  = 1'b1;
                        inc_two = !bw_r;
                    end
                    // Format II's single operand is the source; no dst fetch.
                    nxt = (ad_r && !fmt2_r) ? ST_DST_EXT : ST_EXEC;
                end
            end
            ST_DST_EXT: begin
                mem_req = 1'b1;
                mab_sel = MAB_PC;
                if (mem_ack) begin
                    ext_ld = 1'b1;
                    pc_inc = 1'b1;
                    nxt    = dec_reads_dst ? ST_DST_RD : ST_EXEC;
                end
            end
            ST_DST_RD: begin
                mem_req = 1'b1;
                mab_sel = MAB_DST;
                if (mem_ack) begin
                    dst_ld = 1'b1;
                    nxt    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                fs      = dec_fs;
                cin_ext = dec_cin;
                sr_we   = dec_writes_sr;
                rf_we   = !ad_r && dec_writes_dst;
                nxt     = (ad_r && dec_writes_dst) ? ST_WB_MEM : ST_RETIRE;
            end
            ST_WB_MEM: begin
                // fs stays on the bus so the write data is stable until ack.
                mem_req = 1'b1;
                mem_we  = 1'b1;
                mab_sel = MAB_DST;
                fs      = dec_fs;
                cin_ext = dec_cin;
                if (mem_ack) nxt = ST_RETIRE;
            end
            ST_RETIRE: begin
                done = 1'b1;
                nxt  = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer. A trace model expands each issued
// instruction into the per-cycle output vectors it must produce; one compare
// process checks every cycle against that trace (idle vector when empty).
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic instr_valid = 1'b0, fmt2 = 1'b0, bw = 1'b0, ad = 1'b0, mem_ack = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic [1:0] as = 2'd0;
    logic instr_ready, mem_req, mem_we, ext_ld, src_ld, dst_ld, bw_out, cin_ext;
    logic rf_we, rf_inc, inc_two, pc_inc, sr_we, done, illegal;
    logic [1:0] mab_sel;
    logic [5:0] fs;

    exec_sequencer #(.FS_W(6)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fmt2(fmt2), .opcode(opcode), .bw(bw), .as(as), .ad(ad),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .mab_sel(mab_sel),
        .ext_ld(ext_ld), .src_ld(src_ld), .dst_ld(dst_ld), .fs(fs), .bw_out(bw_out),
        .cin_ext(cin_ext), .rf_we(rf_we), .rf_inc(rf_inc), .inc_two(inc_two),
        .pc_inc(pc_inc), .sr_we(sr_we), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy, req, we;
        logic [1:0] mab;
        logic       ext, src, dst;
        logic [5:0] fs;
        logic       cin, rfwe, rfinc, inc2, pcinc, srwe, done, ill, chkbw, bw;
    } vec_t;

    vec_t exp_q[$];
    int   total = 0, bad = 0;
    int   cyc = 0, acc_cyc = 0, done_cyc = 0, ack_delay = 0, wait_cnt = 0;
    int   n_done = 0, n_rfwe = 0, n_srwe = 0, n_memop = 0, n_wr = 0, n_ill = 0, n_req = 0;
    bit   chk_en = 1'b0;
    string cur = "reset";

    function automatic vec_t idle_v();
        vec_t v = '0;
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic logic [5:0] exp_fs(input logic f2, input logic [3:0] op);
        if (f2) begin
            case (op)
                4'h0: return FS_RRC;  4'h1: return FS_SWPB;
                4'h2: return FS_RRA;  default: return FS_SXT;
            endcase
        end
        case (op)
            4'h4: return FS_MOV;  4'h5: return FS_ADD;  4'h6: return FS_ADDC;
            4'h7: return FS_SUBC; 4'h8: return FS_SUB;  4'h9: return FS_SUB;
            4'hB: return FS_AND;  4'hC: return FS_BIC;  4'hD: return FS_BIS;
            4'hE: return FS_XOR;  default: return FS_AND;
        endcase
    endfunction

    // One memory access: d wait cycles then the ack cycle carrying the strobes.
    task automatic push_access(input vec_t strobes, input int d);
        vec_t w = strobes;
        w.ext = 0; w.src = 0; w.dst = 0; w.rfinc = 0; w.inc2 = 0; w.pcinc = 0;
        for (int i = 0; i < d; i++) exp_q.push_back(w);
        exp_q.push_back(strobes);
    endtask

    task automatic push_trace(input logic f2, input logic [3:0] op, input logic b,
                              input logic [1:0] a_s, input logic a_d, input int d);
        vec_t v;
        bit legal  = f2 ? (op <= 4'h3) : (op >= 4'h4 && op != 4'hA);
        bit writes = f2 || !(op == 4'h9 || op == 4'hB);
        exp_q.push_back(idle_v());
        if (!legal) begin
            v = idle_v(); v.ill = 1; exp_q.push_back(v);
            return;
        end
        if (a_s == 2'b01) begin
            v = '0; v.req = 1; v.mab = 2'd0; v.ext = 1; v.pcinc = 1; push_access(v, d);
        end
        if (a_s != 2'b00) begin
            v = '0; v.req = 1; v.mab = 2'd1; v.src = 1;
            v.rfinc = (a_s == 2'b11); v.inc2 = (a_s == 2'b11) && !b;
            push_access(v, d);
        end
        if (!f2 && a_d) begin
            v = '0; v.req = 1; v.mab = 2'd0; v.ext = 1; v.pcinc = 1; push_access(v, d);
            if (op != 4'h4) begin
                v = '0; v.req = 1; v.mab = 2'd2; v.dst = 1; push_access(v, d);
            end
        end
        v = '0; v.fs = exp_fs(f2, op); v.chkbw = 1; v.bw = b;
        v.cin  = (f2 && op == 4'h0) || (!f2 && (op == 4'h6 || op == 4'h7));
        v.srwe = !((!f2 && op == 4'h4) || (f2 && op == 4'h1));
        v.rfwe = !a_d && writes;
        exp_q.push_back(v);
        if (a_d && writes) begin
            v.srwe = 0; v.req = 1; v.we = 1; v.mab = 2'd2; push_access(v, d);
        end
        v = '0; v.done = 1; exp_q.push_back(v);
    endtask

    // Memory model: acks after ack_delay wait cycles of a held request.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (wait_cnt == ack_delay) begin mem_ack = 1'b1; wait_cnt = 0; end
            else begin mem_ack = 1'b0; wait_cnt = wait_cnt + 1; end
        end else begin
            mem_ack = 1'b0; wait_cnt = 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin n_done++; done_cyc = cyc; end
        if (rf_we) n_rfwe++;
        if (sr_we) n_srwe++;
        if (illegal) n_ill++;
        if (mem_req) n_req++;
        if (mem_req && mem_ack) n_memop++;
        if (mem_req && mem_ack && mem_we) n_wr++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vec_t e, a;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_v();
            a = {instr_ready, mem_req, mem_we, mab_sel, ext_ld, src_ld, dst_ld, fs,
                 cin_ext, rf_we, rf_inc, inc_two, pc_inc, sr_we, done, illegal,
                 e.chkbw, (e.chkbw ? bw_out : 1'b0)};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s cycle %0d: outputs got=%h want=%h", cur, cyc, a, e);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic clr_counts();
        n_done = 0; n_rfwe = 0; n_srwe = 0; n_memop = 0; n_wr = 0; n_ill = 0; n_req = 0;
    endtask

    task automatic issue(input string name, input logic f2, input logic [3:0] op,
                         input logic b, input logic [1:0] a_s, input logic a_d,
                         input int d, input bit busy_valid);
        int n;
        @(posedge clk); #2;
        cur = name; clr_counts(); ack_delay = d;
        fmt2 = f2; opcode = op; bw = b; as = a_s; ad = a_d; instr_valid = 1'b1;
        acc_cyc = cyc;
        push_trace(f2, op, b, a_s, a_d, d);
        @(posedge clk); #1;
        if (busy_valid) begin
            fmt2 = 1'b1; opcode = 4'hA; bw = ~b; as = 2'b11; ad = 1'b1;
            n = 0;
            while (exp_q.size() > 1 && n < 500) begin @(posedge clk); #1; n++; end
        end
        instr_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk); #1; n++;
            if (n > 500) begin
                total++; bad++;
                $display("FAIL %s timeout: queued=%0d want=0", name, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset instr_ready", instr_ready, 1);
        check("reset mem_req", mem_req, 0);
        check("reset outputs", {done, illegal, fs, rf_we, sr_we, bw_out}, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        issue("ADD R5,R6", 0, 4'h5, 0, 2'b00, 0, 0, 0);
        check("ADD latency", done_cyc - acc_cyc, 2);
        check("ADD rf_we", n_rfwe, 1);
        check("ADD sr_we", n_srwe, 1);
        check("ADD memops", n_memop, 0);

        issue("MOV.B @R4+,R7", 0, 4'h4, 1, 2'b11, 0, 1, 0);
        check("MOV.B latency", done_cyc - acc_cyc, 4);
        check("MOV.B sr_we", n_srwe, 0);
        check("MOV.B memops", n_memop, 1);

        issue("CMP 2(R4),4(R5)", 0, 4'h9, 0, 2'b01, 1, 3, 1);
        check("CMP memops", n_memop, 4);
        check("CMP req cycles", n_req, 16);
        check("CMP writes", n_wr, 0);
        check("CMP rf_we", n_rfwe, 0);
        check("CMP sr_we", n_srwe, 1);
        check("CMP done", n_done, 1);
        check("CMP latency", done_cyc - acc_cyc, 18);

        issue("ADD R5,2(R6)", 0, 4'h5, 0, 2'b00, 1, 1, 0);
        check("ADD mem dst writes", n_wr, 1);
        check("ADD mem dst memops", n_memop, 3);
        check("ADD mem dst latency", done_cyc - acc_cyc, 8);

        issue("DADD illegal", 0, 4'hA, 0, 2'b01, 1, 0, 0);
        check("DADD illegal", n_ill, 1);
        check("DADD req", n_req, 0);
        check("DADD done", n_done, 0);
        issue("fmt2 op4 illegal", 1, 4'h4, 0, 2'b10, 0, 0, 0);
        check("fmt2 op4 illegal", n_ill, 1);
        issue("fmt1 op2 illegal", 0, 4'h2, 0, 2'b00, 0, 0, 0);

        issue("RRC @R4", 1, 4'h0, 0, 2'b10, 0, 0, 0);
        issue("SWPB R5", 1, 4'h1, 0, 2'b00, 0, 0, 0);
        issue("SXT 2(R5)", 1, 4'h3, 0, 2'b01, 1, 2, 0);
        issue("SUBC.B @R4+,R6", 0, 4'h7, 1, 2'b11, 0, 0, 0);
        issue("BIT R4,2(R6)", 0, 4'hB, 0, 2'b00, 1, 0, 0);
        check("BIT no write", n_wr, 0);
        issue("MOV R5,2(R6)", 0, 4'h4, 0, 2'b00, 1, 1, 0);
        check("MOV mem dst memops", n_memop, 2);
        issue("XOR.B 2(R4),R6", 0, 4'hE, 1, 2'b01, 0, 0, 0);

        // Asynchronous reset while a source read is waiting for ack
        cur = "rst in SRC_RD";
        chk_en = 1'b0;
        @(posedge clk); #2;
        clr_counts(); ack_delay = 50;
        fmt2 = 0; opcode = 4'h4; bw = 0; as = 2'b10; ad = 0; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #3;
        check("SRC_RD mem_req before rst", mem_req, 1);
        check("SRC_RD mab_sel before rst", mab_sel, 1);
        rst = 1'b1;
        #1;
        check("rst mem_req", mem_req, 0);
        check("rst instr_ready", instr_ready, 1);
        check("rst outputs", {mem_we, src_ld, done, rf_we, fs, sr_we}, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("rst no done", n_done, 0);
        check("rst no rf_we", n_rfwe, 0);
        exp_q.delete();
        chk_en = 1'b1;

        issue("ADD after rst", 0, 4'h5, 0, 2'b00, 0, 0, 0);
        check("ADD after rst latency", done_cyc - acc_cyc, 2);
        check("ADD after rst done", n_done, 1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
